mem_bus_arbiter: RTL and testbench

- Owns the single external memory bus and shares it between three requesters: the CPU (default owner), the OAM DMA engine and an auxiliary bulk-copy master (boot loader/HDMA-style).
- Replaces per-master tristate gating with an explicit registered-grant FSM and a combinational bus mux.
- Inserts one dead turnaround cycle at every ownership change.
- Enforces a fairness window so the aux master cannot starve the CPU.

---
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the three memory requesters (CPU, OAM DMA, aux copy
// master) and the arbiter that owns the single external memory bus.
// master: the requester side. slave: the arbiter side.
interface mem_bus_arbiter_if;
    logic        cpu_re;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;

    logic        dma_req;
    logic        dma_re;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;

    logic        aux_req;
    logic        aux_re;
    logic        aux_we;
    logic [15:0] aux_addr;
    logic [7:0]  aux_wdata;

    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    logic        gnt_dma;
    logic        gnt_aux;
    logic        cpu_stall;
    logic [1:0]  owner;

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_re, dma_we, dma_addr, dma_wdata,
        output aux_req, aux_re, aux_we, aux_addr, aux_wdata,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        input  gnt_dma, gnt_aux, cpu_stall, owner
    );

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_re, dma_we, dma_addr, dma_wdata,
        input  aux_req, aux_re, aux_we, aux_addr, aux_wdata,
        output mem_re, mem_we, mem_addr, mem_wdata,
        output gnt_dma, gnt_aux, cpu_stall, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Registered-grant arbiter for the external memory bus. The CPU owns the bus
// by default; OAM DMA and the aux copy master take it through a one-cycle
// dead turnaround. A hold window stops the aux master from starving the CPU.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_CPU  | CPU owns the bus, no stall
// S_TURN | dead cycle between owners, all strobes blocked, CPU stalled
// S_DMA  | OAM DMA owns the bus until dma_req drops (not preemptible)
// S_AUX  | aux master owns the bus, bounded by the hold window
module mem_bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input logic               clock,
    input logic               reset,
    mem_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_CPU  = 2'b00,
        S_DMA  = 2'b01,
        S_AUX  = 2'b10,
        S_TURN = 2'b11
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q,     state_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic              cpu_owed_q,  cpu_owed_d;
    logic              gnt_dma_q,   gnt_dma_d;
    logic              gnt_aux_q,   gnt_aux_d;
    logic              cpu_stall_q, cpu_stall_d;
    logic [1:0]        owner_q,     owner_d;

    logic cpu_pend;
    logic hold_done;

    assign cpu_pend  = bus.cpu_re | bus.cpu_we;
    // Compare as >= so a CPU access that shows up after the counter has
    // saturated still forces the aux master off the bus.
    assign hold_done = (hold_cnt_q >= HOLD_LAST);

    // Next-state, hold-window and owed-CPU bookkeeping, plus the Moore
    // decode of the next state so the outputs come straight from flops.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cpu_owed_d = cpu_owed_q;

        case (state_q)
            S_CPU: begin
                if (bus.dma_req || bus.aux_req) begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                if (bus.dma_req) begin
                    state_d = S_DMA;
                end else if (cpu_owed_q && cpu_pend) begin
                    state_d    = S_CPU;
                    cpu_owed_d = 1'b0;
                end else if (bus.aux_req) begin
                    state_d    = S_AUX;
                    hold_cnt_d = '0;
                end else begin
                    state_d    = S_CPU;
                    cpu_owed_d = 1'b0;
                end
            end
            S_DMA: begin
                if (!bus.dma_req) begin
                    state_d = S_TURN;
                end
            end
            S_AUX: begin
                hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
                if (hold_done && cpu_pend) begin
                    cpu_owed_d = 1'b1;
                    state_d    = S_TURN;
                end
                if (bus.dma_req || !bus.aux_req) begin
                    state_d = S_TURN;
                end
            end
            default: begin
                state_d = S_CPU;
            end
        endcase

        gnt_dma_d   = (state_d == S_DMA);
        gnt_aux_d   = (state_d == S_AUX);
        cpu_stall_d = (state_d != S_CPU);
        owner_d     = state_d;
    end

    // State and registered outputs; reset returns the bus to the CPU from
    // any state, including the middle of a DMA burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_CPU;
            hold_cnt_q  <= '0;
            cpu_owed_q  <= 1'b0;
            gnt_dma_q   <= 1'b0;
            gnt_aux_q   <= 1'b0;
            cpu_stall_q <= 1'b0;
            owner_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cpu_owed_q  <= cpu_owed_d;
            gnt_dma_q   <= gnt_dma_d;
            gnt_aux_q   <= gnt_aux_d;
            cpu_stall_q <= cpu_stall_d;
            owner_q     <= owner_d;
        end
    end

    assign bus.gnt_dma   = gnt_dma_q;
    assign bus.gnt_aux   = gnt_aux_q;
    assign bus.cpu_stall = cpu_stall_q;
    assign bus.owner     = owner_q;

    // Bus mux: only the current owner's strobes reach memory; turnaround
    // drives an all-zero idle bus.
    always_comb begin
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 8'h00;
        case (state_q)
            S_CPU: begin
                bus.mem_re    = bus.cpu_re;
                bus.mem_we    = bus.cpu_we;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
            end
            S_DMA: begin
                bus.mem_re    = bus.dma_re;
                bus.mem_we    = bus.dma_we;
                bus.mem_addr  = bus.dma_addr;
                bus.mem_wdata = bus.dma_wdata;
            end
            S_AUX: begin
                bus.mem_re    = bus.aux_re;
                bus.mem_we    = bus.aux_we;
                bus.mem_addr  = bus.aux_addr;
                bus.mem_wdata = bus.aux_wdata;
            end
            default: begin
                bus.mem_re    = 1'b0;
                bus.mem_we    = 1'b0;
                bus.mem_addr  = 16'h0000;
                bus.mem_wdata = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a fixed vector table, hand-written
// corner sequences and a randomized run, all shadowed by an ownership model.
module tb_mem_bus_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int OWN_CPU  = 0;
    localparam int OWN_DMA  = 1;
    localparam int OWN_AUX  = 2;
    localparam int OWN_TURN = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ownership model: who holds the bus, how many aux cycles have elapsed
    // in the current aux tenure, and whether the CPU is owed a slot
    int m_own  = OWN_CPU;
    int m_run  = 0;
    bit m_owed = 1'b0;

    typedef struct packed {
        logic       rst;
        logic       cre;
        logic       cwe;
        logic       dreq;
        logic       dwe;
        logic       areq;
        logic       are;
        logic [1:0] own;
        logic       mre;
        logic       mwe;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.cpu_re = 1'b0; bus.cpu_we = 1'b0;
        bus.dma_req = 1'b0; bus.dma_re = 1'b0; bus.dma_we = 1'b0;
        bus.aux_req = 1'b0; bus.aux_re = 1'b0; bus.aux_we = 1'b0;
    endtask

    task automatic check_outputs();
        logic er, ew;
        logic [15:0] ea;
        logic [7:0]  ed;
        er = 1'b0; ew = 1'b0; ea = 16'h0000; ed = 8'h00;
        case (m_own)
            OWN_CPU: begin er = bus.cpu_re; ew = bus.cpu_we; ea = bus.cpu_addr; ed = bus.cpu_wdata; end
            OWN_DMA: begin er = bus.dma_re; ew = bus.dma_we; ea = bus.dma_addr; ed = bus.dma_wdata; end
            OWN_AUX: begin er = bus.aux_re; ew = bus.aux_we; ea = bus.aux_addr; ed = bus.aux_wdata; end
            default: begin er = 1'b0; ew = 1'b0; ea = 16'h0000; ed = 8'h00; end
        endcase
        chk("owner",     32'(bus.owner),     32'(m_own));
        chk("gnt_dma",   32'(bus.gnt_dma),   32'(m_own == OWN_DMA));
        chk("gnt_aux",   32'(bus.gnt_aux),   32'(m_own == OWN_AUX));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(m_own != OWN_CPU));
        chk("mem_re",    32'(bus.mem_re),    32'(er));
        chk("mem_we",    32'(bus.mem_we),    32'(ew));
        chk("mem_addr",  32'(bus.mem_addr),  32'(ea));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
        chk("one_grant", 32'(bus.gnt_dma & bus.gnt_aux), 32'd0);
    endtask

    task automatic model_next();
        bit cpend;
        bit fair_out;
        cpend    = bus.cpu_re | bus.cpu_we;
        fair_out = (m_run >= MAX_HOLD - 1) && cpend;
        if (reset) begin
            m_own = OWN_CPU; m_run = 0; m_owed = 1'b0;
            return;
        end
        case (m_own)
            OWN_CPU: if (bus.dma_req || bus.aux_req) m_own = OWN_TURN;
            OWN_DMA: if (!bus.dma_req) m_own = OWN_TURN;
            OWN_AUX: begin
                if (fair_out) m_owed = 1'b1;
                if (bus.dma_req || !bus.aux_req || fair_out) m_own = OWN_TURN;
                m_run++;
            end
            default: begin
                if (bus.dma_req) m_own = OWN_DMA;
                else if (m_owed && cpend) begin m_own = OWN_CPU; m_owed = 1'b0; end
                else if (bus.aux_req) begin m_own = OWN_AUX; m_run = 0; end
                else begin m_own = OWN_CPU; m_owed = 1'b0; end
            end
        endcase
    endtask

    // one bus cycle: check mid-cycle, advance the model, step past the edge
    task automatic tick();
        @(negedge clock);
        check_outputs();
        model_next();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_owner(input string name, input logic [1:0] own);
        #1;
        chk(name, 32'(bus.owner), 32'(own));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int leaks;
        int run;
        int waited;
        logic [15:0] ea;

        clear_inputs();
        bus.cpu_addr = 16'hC000; bus.cpu_wdata = 8'h5A;
        bus.dma_addr = 16'hFE00; bus.dma_wdata = 8'h11;
        bus.aux_addr = 16'h8000; bus.aux_wdata = 8'h22;

        // {rst, cpu_re, cpu_we, dma_req, dma_we, aux_req, aux_re, owner, mem_re, mem_we}
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};

        // reset state
        @(posedge clock); #1;
        m_own = OWN_CPU; m_run = 0; m_owed = 1'b0;
        chk("rst_owner",     32'(bus.owner),     32'd0);
        chk("rst_gnt_dma",   32'(bus.gnt_dma),   32'd0);
        chk("rst_gnt_aux",   32'(bus.gnt_aux),   32'd0);
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // vector table
        for (int i = 0; i < 12; i++) begin
            reset       = tbl[i].rst;
            bus.cpu_re  = tbl[i].cre;
            bus.cpu_we  = tbl[i].cwe;
            bus.dma_req = tbl[i].dreq;
            bus.dma_we  = tbl[i].dwe;
            bus.aux_req = tbl[i].areq;
            bus.aux_re  = tbl[i].are;
            #1;
            case (tbl[i].own)
                2'b00:   ea = 16'hC000;
                2'b01:   ea = 16'hFE00;
                2'b10:   ea = 16'h8000;
                default: ea = 16'h0000;
            endcase
            chk($sformatf("vec%0d_owner", i),  32'(bus.owner),    32'(tbl[i].own));
            chk($sformatf("vec%0d_mem_re", i), 32'(bus.mem_re),   32'(tbl[i].mre));
            chk($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we),   32'(tbl[i].mwe));
            chk($sformatf("vec%0d_addr", i),   32'(bus.mem_addr), 32'(ea));
            tick();
        end
        reset = 1'b0;
        clear_inputs();

        // long OAM DMA burst with CPU write pulses that must never leak
        for (int i = 0; i < 10; i++) tick();
        g = 0; leaks = 0;
        for (int i = 0; i < 320; i++) begin
            bus.dma_req  = 1'b1;
            bus.dma_addr = 16'hFE00 + 16'(i);
            bus.dma_we   = (i % 2 == 0);
            bus.cpu_we   = (i % 2 == 1);
            #1;
            if (i == 1) chk("dma_turn_owner", 32'(bus.owner), 32'd3);
            if (i == 2) chk("dma_first_gnt", 32'(bus.gnt_dma), 32'd1);
            if (bus.gnt_dma) g++;
            if (bus.mem_we && !bus.dma_we) leaks++;
            tick();
        end
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.cpu_we = 1'b0;
        expect_owner("dma_drop_cycle", 2'b01);
        g++;
        tick();
        chk("dma_gnt_cycles", 32'(g), 32'd319);
        chk("dma_cpu_leaks", 32'(leaks), 32'd0);
        expect_owner("dma_post_turn", 2'b11);
        tick();
        expect_owner("dma_back_cpu", 2'b00);
        tick();

        // simultaneous DMA and aux requests
        bus.dma_addr = 16'hFE00;
        bus.aux_re = 1'b1; bus.dma_re = 1'b1;
        for (int i = 0; i < 11; i++) begin
            logic [1:0] exp_own [11];
            exp_own = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
            bus.dma_req = (i < 5);
            bus.aux_req = (i < 8);
            expect_owner($sformatf("both_owner_c%0d", i), exp_own[i]);
            if (bus.owner == 2'b11) chk("both_turn_strobes", 32'(bus.mem_re | bus.mem_we), 32'd0);
            tick();
        end
        clear_inputs();

        // aux hold window with a pending CPU read
        bus.aux_req = 1'b1; bus.aux_re = 1'b1; bus.cpu_re = 1'b1;
        waited = 0;
        while (!bus.gnt_aux && waited < 10) begin tick(); waited++; end
        chk("fair_aux_granted", 32'(bus.gnt_aux), 32'd1);
        run = 0;
        while (bus.gnt_aux && run < 40) begin run++; tick(); end
        chk("fair_aux_len", 32'(run), 32'(MAX_HOLD));
        expect_owner("fair_turn1", 2'b11);
        tick();
        expect_owner("fair_cpu_slot", 2'b00);
        chk("fair_cpu_read", 32'(bus.mem_re), 32'd1);
        chk("fair_cpu_addr", 32'(bus.mem_addr), 32'hC000);
        tick();
        bus.cpu_re = 1'b0;
        expect_owner("fair_turn2", 2'b11);
        tick();
        expect_owner("fair_aux_again", 2'b10);
        tick();
        bus.aux_req = 1'b0;
        tick();
        tick();
        clear_inputs();
        tick();

        // DMA preempts aux; aux resumes its held access afterwards
        bus.aux_req = 1'b1; bus.aux_re = 1'b1; bus.aux_addr = 16'h8123;
        waited = 0;
        while (!bus.gnt_aux && waited < 10) begin tick(); waited++; end
        chk("pre_aux_granted", 32'(bus.gnt_aux), 32'd1);
        tick();
        for (int i = 0; i < 7; i++) begin
            logic [1:0] exp_own [7];
            exp_own = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
            bus.dma_req = (i < 4);
            expect_owner($sformatf("pre_owner_c%0d", i), exp_own[i]);
            if (i == 1) chk("pre_aux_dropped", 32'(bus.gnt_aux), 32'd0);
            if (i == 6) chk("pre_aux_resume_addr", 32'(bus.mem_addr), 32'h8123);
            tick();
        end
        clear_inputs();
        tick(); tick(); tick();

        // reset in the middle of a DMA burst
        bus.dma_req = 1'b1; bus.dma_we = 1'b1;
        for (int i = 0; i < 80; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_dma_owner", 32'(bus.owner),     32'd0);
        chk("rst_dma_gnt",   32'(bus.gnt_dma),   32'd0);
        chk("rst_dma_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_dma_mem_we", 32'(bus.mem_we),   32'd0);
        tick();
        clear_inputs();
        tick(); tick(); tick();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) bus.dma_req = ~bus.dma_req;
            if ($urandom_range(0, 19) == 0) bus.aux_req = ~bus.aux_req;
            reset         = ($urandom_range(0, 499) == 0);
            bus.cpu_re    = ($urandom_range(0, 7) == 0);
            bus.cpu_we    = ($urandom_range(0, 7) == 0);
            bus.dma_re    = 1'($urandom);
            bus.dma_we    = 1'($urandom);
            bus.aux_re    = 1'($urandom);
            bus.aux_we    = 1'($urandom);
            bus.cpu_addr  = 16'($urandom);
            bus.dma_addr  = 16'($urandom);
            bus.aux_addr  = 16'($urandom);
            bus.cpu_wdata = 8'($urandom);
            bus.dma_wdata = 8'($urandom);
            bus.aux_wdata = 8'($urandom);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
